// File: rtl/cpu_run_ctrl.sv
// Run/step/halt sequencer producing a one-cycle CPU clock-enable from a programmable prescaler.
// Latency: cpu_en/state registered; step edge sampled at E acts at E+1; first RUN pulse after E+div_sel+1.
// No backpressure: inputs are levels sampled every cycle. `define BREAKPOINT_EN adds the PC breakpoint/BREAK state.
module cpu_run_ctrl #(
  parameter int DIV_WIDTH = 22,
  parameter int PC_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run_req,
  input  logic                 step_req,
  input  logic [DIV_WIDTH-1:0] div_sel,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [PC_WIDTH-1:0]  bp_addr,
  input  logic                 bp_valid,
  output logic                 cpu_en,
  output logic [1:0]           state,
  output logic [15:0]          step_count
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  state_t               cur;
  state_t               nxt;
  logic [DIV_WIDTH-1:0] presc;
  logic [DIV_WIDTH-1:0] presc_nxt;
  logic                 en_nxt;
  logic [1:0]           step_sr;    // [0] = step_req sampled last edge, [1] = the edge before
  logic                 step_edge;
  logic                 presc_zero;
  logic                 bp_hit;

  // A step request is acted on one cycle after the rising level is first sampled.
  assign step_edge  = step_sr[0] & ~step_sr[1];
  assign presc_zero = (presc == '0);
  assign state      = cur;

`ifdef BREAKPOINT_EN
  // A hit is only meaningful at the instant a pulse would otherwise fire.
  assign bp_hit = (cur == ST_RUN) & presc_zero & bp_valid & (pc == bp_addr);
`else
  logic unused_bp;
  assign bp_hit    = 1'b0;
  assign unused_bp = &{1'b0, pc, bp_addr, bp_valid};
`endif

  // Next-state, next-pulse and prescaler update; priority: hit > run low > step edge > expiry.
  always_comb begin
    nxt       = cur;
    en_nxt    = 1'b0;
    presc_nxt = presc;
    case (cur)
      ST_HALT: begin
        if (run_req) begin
          nxt       = ST_RUN;
          presc_nxt = div_sel;
        end else if (step_edge) begin
          nxt    = ST_STEP;
          en_nxt = 1'b1;
        end
      end
      ST_RUN: begin
        if (bp_hit) begin
          nxt = ST_BREAK;
        end else if (!run_req) begin
          nxt = ST_HALT;
        end else if (presc_zero) begin
          en_nxt    = 1'b1;
          presc_nxt = div_sel;
        end else begin
          presc_nxt = presc - DIV_WIDTH'(1);
        end
      end
      ST_STEP: begin
        // The pulse is already on cpu_en for this cycle; always drop back to HALT.
        nxt = ST_HALT;
      end
      ST_BREAK: begin
`ifdef BREAKPOINT_EN
        if (!run_req) begin
          nxt = ST_HALT;
        end else if (step_edge) begin
          nxt    = ST_STEP;
          en_nxt = 1'b1;
        end
`else
        nxt = ST_HALT;
`endif
      end
      default: nxt = ST_HALT;
    endcase
  end

  // State, prescaler, registered enable pulse and step edge history.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur     <= ST_HALT;
      presc   <= '0;
      cpu_en  <= 1'b0;
      step_sr <= 2'b00;
    end else begin
      cur     <= nxt;
      presc   <= presc_nxt;
      cpu_en  <= en_nxt;
      step_sr <= {step_sr[0], step_req};
    end
  end

  // Count every cycle the CPU was enabled; wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_count <= 16'd0;
    end else if (cpu_en) begin
      step_count <= step_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: schedule-based reference model compared every cycle,
// plus directed scenarios with hand-computed expectations and a randomized phase.
// Define BREAKPOINT_EN for both this file and the RTL to exercise the breakpoint scenario.
module tb_cpu_run_ctrl;
  localparam int DW = 22;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          run_req;
  logic          step_req;
  logic [DW-1:0] div_sel;
  logic [PW-1:0] pc;
  logic [PW-1:0] bp_addr;
  logic          bp_valid;
  wire           cpu_en;
  wire  [1:0]    state;
  wire  [15:0]   step_count;

  int checks = 0;
  int errors = 0;
  bit cmp_on = 1'b0;

  cpu_run_ctrl #(.DIV_WIDTH(DW), .PC_WIDTH(PW)) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .div_sel(div_sel), .pc(pc), .bp_addr(bp_addr), .bp_valid(bp_valid),
    .cpu_en(cpu_en), .state(state), .step_count(step_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Reference model: modes 0=HALT 1=RUN 2=STEP 3=BREAK; RUN pulses are an absolute
  // cycle schedule (next pulse edge = entry edge + div_sel + 1, re-armed at each pulse).
  int          m_mode;
  longint      m_cyc;
  longint      m_next;
  bit          m_en;
  logic [15:0] m_cnt;
  bit          m_s_new;
  bit          m_s_old;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_mode = 0; m_en = 0; m_cnt = 16'd0; m_cyc = 0; m_next = 0;
      m_s_new = 0; m_s_old = 0;
    end else begin
      bit rise;
      bit due;
      bit hit;
      bit fire;
      rise    = m_s_new && !m_s_old;
      m_s_old = m_s_new;
      m_s_new = step_req;
      if (m_en) m_cnt = m_cnt + 16'd1;
      m_cyc++;
      fire = 0;
      due  = (m_mode == 1) && (m_cyc == m_next);
      hit  = 0;
`ifdef BREAKPOINT_EN
      hit = due && bp_valid && (pc == bp_addr);
`endif
      case (m_mode)
        0: if (run_req) begin m_mode = 1; m_next = m_cyc + longint'(div_sel) + 1; end
           else if (rise) begin m_mode = 2; fire = 1; end
        1: if (hit) m_mode = 3;
           else if (!run_req) m_mode = 0;
           else if (due) begin fire = 1; m_next = m_cyc + longint'(div_sel) + 1; end
        2: m_mode = 0;
        default: if (!run_req) m_mode = 0;
                 else if (rise) begin m_mode = 2; fire = 1; end
      endcase
      m_en = fire;
    end
  end

  // Compare all outputs against the model shortly after every active edge.
  always @(posedge clk) begin
    #1;
    if (cmp_on && !reset) begin
      chk("model_cpu_en", {31'd0, cpu_en}, {31'd0, m_en});
      chk("model_state", {30'd0, state}, m_mode);
      chk("model_step_count", {16'd0, step_count}, {16'd0, m_cnt});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; run_req = 1'b0; step_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int np, first, second, post;
    bit done;
    reset = 1'b1; run_req = 0; step_req = 0; div_sel = '0;
    pc = '0; bp_addr = '0; bp_valid = 0;
    #1;
    chk("reset_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("reset_state", {30'd0, state}, 32'd0);
    chk("reset_step_count", {16'd0, step_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cmp_on = 1'b1;

    // Free-run, div_sel=3: pulses at negedges 5, 9, ... after run_req is set.
    do_reset();
    div_sel = 3; run_req = 1;
    np = 0; first = 0; second = 0;
    for (int k = 1; k <= 60 && np < 10; k++) begin
      @(negedge clk);
      if (cpu_en) begin
        np++;
        if (np == 1) first = k;
        if (np == 2) second = k;
      end
    end
    if (np < 10) timeout("freerun_pulses");
    @(negedge clk);
    chk("freerun_first", first, 5);
    chk("freerun_second", second, 9);
    chk("freerun_count10", {16'd0, step_count}, 32'd10);
    run_req = 0;

    // Continuous enable: 20 pulses, then none after HALT.
    do_reset();
    div_sel = 0; run_req = 1;
    np = 0;
    repeat (21) begin @(negedge clk); if (cpu_en) np++; end
    run_req = 0;
    post = 0;
    repeat (10) begin @(negedge clk); if (cpu_en) post++; end
    chk("cont_pulses", np, 20);
    chk("cont_after_halt", post, 0);
    chk("cont_state", {30'd0, state}, 32'd0);

    // Single step with a held button, then a second press.
    do_reset();
    div_sel = 5; step_req = 1;
    np = 0; first = 0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (cpu_en) begin np++; if (np == 1) first = k; end
    end
    chk("step_held_pulses", np, 1);
    chk("step_latency", first, 2);
    step_req = 0; repeat (5) @(negedge clk);
    step_req = 1; repeat (5) @(negedge clk);
    step_req = 0; repeat (3) @(negedge clk);
    chk("step_count2", {16'd0, step_count}, 32'd2);

`ifdef BREAKPOINT_EN
    // Breakpoint at 0x05 with pc advancing on each pulse.
    do_reset();
    bp_addr = 8'h05; bp_valid = 1; pc = 0; div_sel = 2; run_req = 1;
    np = 0; done = 0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (cpu_en) begin np++; pc = pc + 1'b1; end
      if (state == 2'b11) done = 1;
    end
    if (!done) timeout("bp_reach_break");
    chk("bp_pulses", np, 5);
    chk("bp_pc", {24'd0, pc}, 32'd5);
    chk("bp_no_pulse", {31'd0, cpu_en}, 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_hold_break", {30'd0, state}, 32'd3);
    step_req = 1; done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      @(negedge clk);
      if (cpu_en) begin done = 1; pc = pc + 1'b1; end
    end
    if (!done) timeout("bp_step_pulse");
    @(negedge clk);
    chk("bp_step_halt", {30'd0, state}, 32'd0);
    chk("bp_step_pc", {24'd0, pc}, 32'd6);
    step_req = 0; run_req = 0;
    repeat (3) @(negedge clk);
    run_req = 1;
    repeat (2) @(negedge clk);
    chk("bp_resume_run", {30'd0, state}, 32'd1);
    run_req = 0; bp_valid = 0; pc = 0;
`endif

    // Counter wrap: 65535 pulses then one step.
    do_reset();
    div_sel = 0; run_req = 1;
    repeat (65536) @(negedge clk);
    run_req = 0;
    repeat (3) @(negedge clk);
    chk("wrap_ffff", {16'd0, step_count}, 32'h0000FFFF);
    step_req = 1; repeat (4) @(negedge clk);
    step_req = 0; repeat (2) @(negedge clk);
    chk("wrap_zero", {16'd0, step_count}, 32'd0);

    // Asynchronous reset during the second pulse at div_sel=7.
    do_reset();
    div_sel = 7; run_req = 1;
    np = 0;
    for (int k = 0; k < 40 && np < 2; k++) begin
      @(negedge clk);
      if (cpu_en) np++;
    end
    if (np < 2) timeout("midreset_pulse");
    chk("midreset_pre_count", {16'd0, step_count}, 32'd1);
    #2;
    reset = 1; run_req = 0;
    #1;
    chk("midreset_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("midreset_state", {30'd0, state}, 32'd0);
    chk("midreset_count", {16'd0, step_count}, 32'd0);
    @(negedge clk);
    reset = 0;
    post = 0;
    repeat (30) begin @(negedge clk); if (cpu_en) post++; end
    chk("midreset_no_pulse", post, 0);

    // Randomized phase, checked cycle by cycle against the model.
    do_reset();
    bp_addr = PW'($urandom_range(0, 7));
    repeat (3000) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) run_req = ~run_req;
      if ($urandom_range(0, 5) == 0) step_req = ~step_req;
      if ($urandom_range(0, 19) == 0) div_sel = DW'($urandom_range(0, 5));
      if ($urandom_range(0, 2) == 0) pc = PW'($urandom_range(0, 7));
      if ($urandom_range(0, 30) == 0) bp_valid = ~bp_valid;
    end
    run_req = 0; step_req = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
